// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - registered execute-stage ALU with valid/ready handshakes
// Optional iterative multiplier on ALUControl 100 enabled by ALU_EXEC_MUL_EN.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  logic             in_xfer;
  logic             out_xfer;
  logic             out_free;
  logic             is_mul;
  logic             load_single;
  logic             load_mul;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [WIDTH-1:0] mul_res;

  assign out_xfer    = out_valid && out_ready;
  assign out_free    = !out_valid || out_ready;
  assign in_xfer     = in_valid && in_ready;
  assign load_single = in_xfer && !is_mul;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_ctrl)
      3'b000:  alu_res = src_a + src_b;
      3'b001:  alu_res = src_a - src_b;
      3'b010:  alu_res = src_a & src_b;
      3'b011:  alu_res = src_a | src_b;
      3'b101:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    cnt;

  assign is_mul   = (alu_ctrl == 3'b100);
  assign in_ready = rst_n && (state == IDLE) && out_free;
  assign load_mul = (state == DONE) && out_free;
  assign mul_res  = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_xfer && is_mul) state_nxt = MUL;
      MUL:     if (cnt == CW'(WIDTH)) state_nxt = DONE;
      DONE:    if (load_mul) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only the low WIDTH bits of the product are kept, so the shifted
  // multiplicand can simply drop its overflow bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == IDLE) begin
      if (in_xfer && is_mul) begin
        mcand  <= src_a;
        mplier <= src_b;
        acc    <= '0;
        cnt    <= '0;
      end
    end else if (state == MUL && cnt != CW'(WIDTH)) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign in_ready = rst_n && out_free;
  assign load_mul = 1'b0;
  assign mul_res  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (load_single) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      zero      <= (alu_res == '0);
      illegal   <= alu_ill;
    end else if (load_mul) begin
      out_valid <= 1'b1;
      result    <= mul_res;
      zero      <= (mul_res == '0);
      illegal   <= 1'b0;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed and random checks of alu_exec_unit
// Expectations follow ALU_EXEC_MUL_EN when it is defined for the build.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int vectors = 0;
  int miscompares = 0;

`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {illegal, zero, result} from the ALUControl definitions.
  function automatic logic [33:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        ill;
    logic [63:0] p;
    r   = 32'd0;
    ill = 1'b0;
    p   = 64'd0;
    case (c)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: begin
        if (MUL_EN) begin
          p = {32'd0, a} * {32'd0, b};
          r = p[31:0];
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    return {ill, (r == 32'd0), r};
  endfunction

  // Offers one op, waits for the transfer, then measures latency and result.
  task automatic run_op(input string tag, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [33:0] exp;
    int          n;
    int          exp_lat;
    bit          busy_ready;
    exp       = model(c, a, b);
    exp_lat   = (c == 3'd4 && MUL_EN) ? 34 : 1;
    alu_ctrl  = c;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check({tag, "_accept_timeout"}, 64'(n), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    busy_ready = 1'b0;
    while (n <= 200) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      if (in_ready) busy_ready = 1'b1;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_result"}, 64'(result), 64'(exp[31:0]));
    check({tag, "_zero"}, 64'(zero), 64'(exp[32]));
    check({tag, "_illegal"}, 64'(illegal), 64'(exp[33]));
    if (exp_lat > 1) check({tag, "_busy_in_ready"}, 64'(busy_ready), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          seen;
    logic [2:0]  rc;
    logic [31:0] ra, rb;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    alu_ctrl  = 3'b000;
    src_a     = 32'd1;
    src_b     = 32'd2;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    run_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd1);
    run_op("sub_neg", 3'b001, 32'd5, 32'd7);
    run_op("slt_m1_1", 3'b101, 32'hFFFF_FFFF, 32'd1);
    run_op("slt_1_m1", 3'b101, 32'd1, 32'hFFFF_FFFF);
    run_op("and", 3'b010, 32'h0000_F0F0, 32'h0000_FF00);
    run_op("or", 3'b011, 32'h0000_F0F0, 32'h0000_0F00);
    run_op("ill_110", 3'b110, 32'd9, 32'd9);
    run_op("after_ill", 3'b000, 32'd4, 32'd5);
    run_op("ill_111", 3'b111, 32'd1, 32'd2);
    run_op("mul_3x4", 3'b100, 32'd3, 32'd4);
    run_op("mul_ovf", 3'b100, 32'h0001_0000, 32'h0001_0000);
    run_op("mul_123x456", 3'b100, 32'd123, 32'd456);

    // Backpressure: second op stays pending until the first result drains.
    out_ready = 1'b0;
    run_op("bp_first", 3'b000, 32'd1, 32'd2);
    alu_ctrl = 3'b000;
    src_a    = 32'd3;
    src_b    = 32'd4;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_result", 64'(result), 64'd3);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_result", 64'(result), 64'd3);
    check("bp_drain_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid", 64'(out_valid), 64'd1);
    check("bp_second_result", 64'(result), 64'd7);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_empty", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

`ifdef ALU_EXEC_MUL_EN
    // Product completes with the consumer stalled and must stay put.
    out_ready = 1'b0;
    run_op("mul_stall", 3'b100, 32'd123, 32'd456);
    repeat (3) begin
      @(negedge clk);
      check("mul_stall_valid", 64'(out_valid), 64'd1);
      check("mul_stall_result", 64'(result), 64'd56088);
      check("mul_stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-multiply discards the op.
    alu_ctrl = 3'b100;
    src_a    = 32'd123;
    src_b    = 32'd456;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_result", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
`endif

    for (int i = 0; i < 40; i++) begin
      rc = 3'($urandom_range(0, 7));
      ra = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      out_ready = 1'b1;
      run_op("rand", rc, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
